// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer
//   Packet-level controller for the USB receive path. Checks the PID,
//   clears the CRC checkers at the start of each packet body, forwards
//   data payload bytes (the trailing CRC16 bytes are held back in a
//   2-deep pipe and dropped), and reports one classification per packet.
//
//   Optional feature macro: USB_RX_SEQ_CRC_EN
//     defined   : crc5_err/crc16_err are checked, crc*_clear are driven
//     undefined : CRC inputs ignored, crc*_clear tied low
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   sync_byte                 SYNC detected (starts a packet from IDLE)
//   byte_done, packet_in[7:0] new received byte strobe + value
//   eop                       end of packet
//   crc5_err, crc16_err       CRC checker status, sampled with eop
//   crc5_clear, crc16_clear   one-cycle clears after a good PID
//   rx_data[7:0], store_rx_data  payload byte + strobe
//   rx_packet[2:0]            packet class (NONE/OUT/IN/DATA0/DATA1/ACK/NAK/ERROR)
//   rx_done                   one-cycle result strobe
//   rx_byte_count[6:0]        payload bytes stored in the last packet
//   rx_busy                   FSM not in IDLE
module usb_rx_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync_byte,
   input  logic       byte_done,
   input  logic [7:0] packet_in,
   input  logic       eop,
   input  logic       crc5_err,
   input  logic       crc16_err,
   output logic       crc5_clear,
   output logic       crc16_clear,
   output logic [7:0] rx_data,
   output logic       store_rx_data,
   output logic [2:0] rx_packet,
   output logic       rx_done,
   output logic [6:0] rx_byte_count,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHK, S_ERR
   } state_t;

   localparam logic [2:0] P_OUT   = 3'd1;
   localparam logic [2:0] P_IN    = 3'd2;
   localparam logic [2:0] P_DATA0 = 3'd3;
   localparam logic [2:0] P_DATA1 = 3'd4;
   localparam logic [2:0] P_ACK   = 3'd5;
   localparam logic [2:0] P_NAK   = 3'd6;
   localparam logic [2:0] P_ERROR = 3'd7;

   localparam logic [6:0] MAX_PAYLOAD = 7'd64;

   state_t          state_q, state_n;
   logic [2:0]      pcls_q, pcls_n;     // class implied by the accepted PID
   logic [1:0]      tcnt_q, tcnt_n;     // token body byte count
   logic [6:0]      cnt_q, cnt_n;       // payload bytes stored
   logic [1:0][7:0] pipe_q, pipe_n;     // [1] oldest, [0] newest
   logic [1:0]      fill_q, fill_n;
   logic            clr_q, clr_n;
   logic [7:0]      data_q, data_n;
   logic            store_q, store_n;
   logic            done_q, done_n;
   logic [2:0]      pkt_q, pkt_n;
   logic [6:0]      bc_q, bc_n;

   logic crc5_bad, crc16_bad;
   logic pid_ok;

`ifdef USB_RX_SEQ_CRC_EN
   assign crc5_bad    = crc5_err;
   assign crc16_bad   = crc16_err;
   assign crc5_clear  = clr_q;
   assign crc16_clear = clr_q;
`else
   assign crc5_bad    = 1'b0;
   assign crc16_bad   = 1'b0;
   assign crc5_clear  = 1'b0;
   assign crc16_clear = 1'b0;
   logic unused_crc;
   assign unused_crc  = crc5_err ^ crc16_err ^ clr_q;
`endif

   // PID byte carries its own check nibble
   assign pid_ok = (packet_in[7:4] == ~packet_in[3:0]);

   always_comb begin
      state_n = state_q;
      pcls_n  = pcls_q;
      tcnt_n  = tcnt_q;
      cnt_n   = cnt_q;
      pipe_n  = pipe_q;
      fill_n  = fill_q;
      clr_n   = 1'b0;
      data_n  = data_q;
      store_n = 1'b0;
      done_n  = 1'b0;
      pkt_n   = pkt_q;
      bc_n    = bc_q;

      if (state_q != S_IDLE && eop) begin
         // Any eop inside a packet closes it; a byte arriving in the
         // same cycle makes the framing invalid and is not stored.
         state_n = S_IDLE;
         done_n  = 1'b1;
         bc_n    = cnt_q;
         pkt_n   = P_ERROR;
         if (!byte_done) begin
            case (state_q)
               S_TOKEN: if (tcnt_q == 2'd2 && !crc5_bad)  pkt_n = pcls_q;
               S_DATA:  if (fill_q == 2'd2 && !crc16_bad) pkt_n = pcls_q;
               S_HSHK:  pkt_n = pcls_q;
               default: ;
            endcase
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sync_byte) begin
                  state_n = S_PID;
                  tcnt_n  = 2'd0;
                  cnt_n   = 7'd0;
                  fill_n  = 2'd0;
               end
            end
            S_PID: begin
               if (byte_done) begin
                  state_n = S_ERR;
                  if (pid_ok) begin
                     case (packet_in)
                        8'hE1: begin state_n = S_TOKEN; pcls_n = P_OUT;   end
                        8'h69: begin state_n = S_TOKEN; pcls_n = P_IN;    end
                        8'hC3: begin state_n = S_DATA;  pcls_n = P_DATA0; end
                        8'h4B: begin state_n = S_DATA;  pcls_n = P_DATA1; end
                        8'hD2: begin state_n = S_HSHK;  pcls_n = P_ACK;   end
                        8'h5A: begin state_n = S_HSHK;  pcls_n = P_NAK;   end
                        default: ;
                     endcase
                  end
                  clr_n = (state_n != S_ERR);
               end
            end
            S_TOKEN: begin
               if (byte_done) begin
                  if (tcnt_q == 2'd2) state_n = S_ERR;
                  else                tcnt_n  = tcnt_q + 2'd1;
               end
            end
            S_DATA: begin
               if (byte_done) begin
                  if (fill_q == 2'd2 && cnt_q == MAX_PAYLOAD) begin
                     state_n = S_ERR;   // payload overflow; count stays at 64
                  end else begin
                     // Only release the oldest byte once two newer ones
                     // exist: the last two bytes of the packet are CRC16.
                     if (fill_q == 2'd2) begin
                        data_n  = pipe_q[1];
                        store_n = 1'b1;
                        cnt_n   = cnt_q + 7'd1;
                     end else begin
                        fill_n  = fill_q + 2'd1;
                     end
                     pipe_n[1] = pipe_q[0];
                     pipe_n[0] = packet_in;
                  end
               end
            end
            S_HSHK: begin
               if (byte_done) state_n = S_ERR;
            end
            default: ;  // S_ERR waits for eop
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pcls_q  <= 3'd0;
         tcnt_q  <= 2'd0;
         cnt_q   <= 7'd0;
         pipe_q  <= '0;
         fill_q  <= 2'd0;
         clr_q   <= 1'b0;
         data_q  <= 8'h00;
         store_q <= 1'b0;
         done_q  <= 1'b0;
         pkt_q   <= 3'd0;
         bc_q    <= 7'd0;
      end else begin
         state_q <= state_n;
         pcls_q  <= pcls_n;
         tcnt_q  <= tcnt_n;
         cnt_q   <= cnt_n;
         pipe_q  <= pipe_n;
         fill_q  <= fill_n;
         clr_q   <= clr_n;
         data_q  <= data_n;
         store_q <= store_n;
         done_q  <= done_n;
         pkt_q   <= pkt_n;
         bc_q    <= bc_n;
      end
   end

   assign rx_data       = data_q;
   assign store_rx_data = store_q;
   assign rx_done       = done_q;
   assign rx_packet     = pkt_q;
   assign rx_byte_count = bc_q;
   assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer: table of whole packets plus
// hand-written sequences for timing, overflow, reset and framing corners.
module tb_usb_rx_sequencer;

`ifdef USB_RX_SEQ_CRC_EN
   localparam bit CRC = 1'b1;
`else
   localparam bit CRC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, sync_byte, byte_done, eop, crc5_err, crc16_err;
   logic [7:0] packet_in;
   logic       crc5_clear, crc16_clear, store_rx_data, rx_done, rx_busy;
   logic [7:0] rx_data;
   logic [2:0] rx_packet;
   logic [6:0] rx_byte_count;

   usb_rx_sequencer dut (
      .clk(clk), .rst(rst), .sync_byte(sync_byte), .byte_done(byte_done),
      .packet_in(packet_in), .eop(eop), .crc5_err(crc5_err), .crc16_err(crc16_err),
      .crc5_clear(crc5_clear), .crc16_clear(crc16_clear), .rx_data(rx_data),
      .store_rx_data(store_rx_data), .rx_packet(rx_packet), .rx_done(rx_done),
      .rx_byte_count(rx_byte_count), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Event monitor, sampled away from the active edge
   int         n_store = 0, n_clr5 = 0, n_clr16 = 0, n_done = 0;
   logic [7:0] sq[$];
   always @(negedge clk) begin
      if (store_rx_data) begin n_store++; sq.push_back(rx_data); end
      if (crc5_clear)  n_clr5++;
      if (crc16_clear) n_clr16++;
      if (rx_done)     n_done++;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      sync_byte = 0; byte_done = 0; eop = 0; crc5_err = 0; crc16_err = 0;
   endtask

   task automatic send_sync(); sync_byte = 1; cyc(); endtask
   task automatic send_byte(input logic [7:0] b);
      byte_done = 1; packet_in = b; cyc(); cyc();   // idle gap between bytes
   endtask
   task automatic send_eop(input logic c5, input logic c16);
      eop = 1; crc5_err = c5; crc16_err = c16; cyc();
   endtask

   function automatic bit good_pid(input logic [7:0] p);
      return p == 8'hE1 || p == 8'h69 || p == 8'hC3 ||
             p == 8'h4B || p == 8'hD2 || p == 8'h5A;
   endfunction

   typedef struct {
      string       name;
      logic [7:0]  pid;
      int          n;       // body bytes after the PID
      logic [47:0] bytes;   // first body byte in the top byte
      logic        c5, c16;
      logic [2:0]  pkt;
      int          cnt;     // expected stored payload bytes
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [7:0] pid, input int n,
                               input logic [47:0] b, input logic c5, input logic c16,
                               input logic [2:0] pkt, input int cnt);
      vec_t v;
      v.name = nm; v.pid = pid; v.n = n; v.bytes = b; v.c5 = c5; v.c16 = c16;
      v.pkt = pkt; v.cnt = cnt;
      return v;
   endfunction

   vec_t vt[$];

   task automatic run_vec(input vec_t v);
      int s0, c0, d0;
      logic [7:0] b;
      s0 = n_store; c0 = n_clr5; d0 = n_clr16;
      send_sync();
      send_byte(v.pid);
      for (int k = 0; k < v.n; k++) begin
         b = v.bytes[47 - 8*k -: 8];
         send_byte(b);
      end
      send_eop(v.c5, v.c16);
      chk({v.name, ".done"},  int'(rx_done), 1);
      chk({v.name, ".pkt"},   int'(rx_packet), int'(v.pkt));
      chk({v.name, ".count"}, int'(rx_byte_count), v.cnt);
      cyc(); cyc();
      chk({v.name, ".stores"}, n_store - s0, v.cnt);
      for (int k = 0; k < v.cnt && k < 6; k++) begin
         b = v.bytes[47 - 8*k -: 8];
         if (s0 + k < sq.size()) chk({v.name, ".byte"}, int'(sq[s0 + k]), int'(b));
      end
      chk({v.name, ".clr5"},  n_clr5 - c0,  (CRC && good_pid(v.pid)) ? 1 : 0);
      chk({v.name, ".clr16"}, n_clr16 - d0, (CRC && good_pid(v.pid)) ? 1 : 0);
   endtask

   initial begin
      int s0, d0;
      rst = 1; sync_byte = 0; byte_done = 0; eop = 0; crc5_err = 0; crc16_err = 0;
      packet_in = 8'h00;
      cyc(); cyc();
      rst = 0;
      chk("reset.busy",  int'(rx_busy), 0);
      chk("reset.pkt",   int'(rx_packet), 0);
      chk("reset.count", int'(rx_byte_count), 0);
      chk("reset.data",  int'(rx_data), 0);
      chk("reset.flags", int'({rx_done, store_rx_data, crc5_clear, crc16_clear}), 0);

      // IDLE ignores byte_done and eop
      d0 = n_done;
      byte_done = 1; packet_in = 8'hD2; cyc();
      eop = 1; cyc(); cyc();
      chk("idle.ignore", n_done - d0, 0);

      vt.push_back(mk("ack",     8'hD2, 0, 48'h0,            0, 0, 3'd5, 0));
      vt.push_back(mk("nak",     8'h5A, 0, 48'h0,            0, 0, 3'd6, 0));
      vt.push_back(mk("in",      8'h69, 2, 48'h8158_00000000, 0, 0, 3'd2, 0));
      vt.push_back(mk("in_crc",  8'h69, 2, 48'h8158_00000000, 1, 0, CRC ? 3'd7 : 3'd2, 0));
      vt.push_back(mk("out",     8'hE1, 2, 48'h1234_00000000, 0, 0, 3'd1, 0));
      vt.push_back(mk("data0",   8'hC3, 5, 48'h112233AABB00, 0, 0, 3'd3, 3));
      vt.push_back(mk("data1_0", 8'h4B, 2, 48'hAABB_00000000, 0, 0, 3'd4, 0));
      vt.push_back(mk("data_sh", 8'hC3, 1, 48'h55_0000000000, 0, 0, 3'd7, 0));
      vt.push_back(mk("data_crc",8'hC3, 3, 48'h112233_000000, 0, 1, CRC ? 3'd7 : 3'd3, 1));
      vt.push_back(mk("badpid",  8'hFF, 2, 48'h0102_00000000, 0, 0, 3'd7, 0));
      vt.push_back(mk("setup",   8'h2D, 2, 48'h0102_00000000, 0, 0, 3'd7, 0));
      vt.push_back(mk("tok_long",8'hE1, 3, 48'h010203_000000, 0, 0, 3'd7, 0));
      vt.push_back(mk("tok_shrt",8'h69, 1, 48'h01_0000000000, 0, 0, 3'd7, 0));
      vt.push_back(mk("hs_byte", 8'hD2, 1, 48'h01_0000000000, 0, 0, 3'd7, 0));
      foreach (vt[i]) run_vec(vt[i]);

      // Store timing: one cycle after the byte_done of the third byte on
      s0 = n_store;
      send_sync(); send_byte(8'hC3);
      byte_done = 1; packet_in = 8'h11; cyc();
      chk("tm.b1", int'(store_rx_data), 0); cyc();
      byte_done = 1; packet_in = 8'h22; cyc();
      chk("tm.b2", int'(store_rx_data), 0); cyc();
      byte_done = 1; packet_in = 8'h33; cyc();
      chk("tm.b3.stb", int'(store_rx_data), 1);
      chk("tm.b3.dat", int'(rx_data), 8'h11); cyc();
      chk("tm.b3.one", int'(store_rx_data), 0);
      // byte_done together with eop: error, byte not stored
      byte_done = 1; packet_in = 8'h44; eop = 1; cyc();
      chk("same.pkt",   int'(rx_packet), 7);
      chk("same.count", int'(rx_byte_count), 1);
      // back-to-back: sync in the rx_done cycle
      chk("b2b.busy", int'(rx_busy), 0);
      send_sync(); send_byte(8'h5A); send_eop(0, 0);
      chk("b2b.pkt", int'(rx_packet), 6);
      cyc(); cyc();
      chk("same.stores", n_store - s0, 1);

      // eop right after sync
      send_sync(); send_eop(0, 0);
      chk("pideop.pkt", int'(rx_packet), 7);
      // sync inside a packet is ignored
      send_sync(); send_byte(8'hE1); send_sync(); send_byte(8'h01); send_byte(8'h02);
      send_eop(0, 0);
      chk("midsync.pkt", int'(rx_packet), 1);

      // Max payload and overflow
      for (int len = 66; len <= 67; len++) begin
         s0 = n_store;
         send_sync(); send_byte(8'h4B);
         for (int k = 0; k < len; k++) begin
            byte_done = 1; packet_in = 8'(k); cyc();
         end
         send_eop(0, 0);
         chk(len == 66 ? "max.pkt" : "ovf.pkt", int'(rx_packet), len == 66 ? 4 : 7);
         chk(len == 66 ? "max.count" : "ovf.count", int'(rx_byte_count), 64);
         cyc(); cyc();
         chk(len == 66 ? "max.stores" : "ovf.stores", n_store - s0, 64);
         chk(len == 66 ? "max.last" : "ovf.last", int'(sq[sq.size() - 1]), 63);
      end

      // Reset mid-packet
      d0 = n_done;
      send_sync(); send_byte(8'h4B);
      send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
      rst = 1; cyc(); rst = 0;
      chk("rst.busy", int'(rx_busy), 0);
      chk("rst.pkt",  int'(rx_packet), 0);
      chk("rst.stb",  int'(store_rx_data), 0);
      eop = 1; cyc(); cyc(); cyc();
      chk("rst.nodone", n_done - d0, 0);
      send_sync(); send_byte(8'hD2); send_eop(0, 0);
      chk("rst.ack", int'(rx_packet), 5);
      chk("rst.ackcnt", int'(rx_byte_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usb_rx_sequencer.md
# usb_rx_sequencer

Packet-level controller for the USB receive datapath. Consumes byte strobes, sync detection, EOP and CRC status from the decoder, shift register and CRC checkers. Validates the PID, sequences the CRC checker clears and classifies the packet. Forwards data payload bytes with the trailing CRC16 bytes stripped, and reports one result per packet to the AHB-side logic.

## Interface
- No parameters. Maximum payload is fixed at 64 bytes.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sync_byte  in  1  one-cycle pulse: SYNC pattern detected by shift register
- byte_done  in  1  one-cycle pulse: packet_in holds a new complete byte
- packet_in  in  8  received byte, LSB-first order already assembled
- eop  in  1  one-cycle pulse: end of packet seen on the bus
- crc5_err  in  1  CRC5 checker error level, valid in the eop cycle
- crc16_err  in  1  CRC16 checker error level, valid in the eop cycle
- crc5_clear  out  1  one-cycle clear to the CRC5 checker
- crc16_clear  out  1  one-cycle clear to the CRC16 checker
- rx_data  out  8  payload byte, valid while store_rx_data=1
- store_rx_data  out  1  one-cycle payload byte strobe
- rx_packet  out  3  packet class, valid from rx_done onward
  - 0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 ERROR
- rx_done  out  1  one-cycle pulse: rx_packet and rx_byte_count updated
- rx_byte_count  out  7  payload bytes stored in the last packet (0..64)
- rx_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PID, TOKEN, DATA, HSHK, ERR.
- IDLE:
  - sync_byte moves the FSM to PID.
  - byte_done and eop are ignored.
- PID:
  - On byte_done, the byte is valid only if packet_in[7:4] == ~packet_in[3:0].
  - Accepted bytes:
    - 0xE1 OUT → TOKEN
    - 0x69 IN → TOKEN
    - 0xC3 DATA0 → DATA
    - 0x4B DATA1 → DATA
    - 0xD2 ACK → HSHK
    - 0x5A NAK → HSHK
  - Any other byte, including SETUP and STALL, → ERR.
  - On entry to TOKEN, DATA or HSHK, crc5_clear and crc16_clear both pulse in the following cycle.
  - eop in PID → report ERROR.
- TOKEN:
  - Counts bytes. Exactly 2 bytes are required before eop.
  - A third byte → ERR.
  - eop with a count ≠ 2 → ERROR.
  - eop with crc5_err=1 → ERROR.
- DATA:
  - Bytes pass through a 2-deep delay pipe.
  - On each byte_done with the pipe already full, the oldest byte is emitted on rx_data/store_rx_data and the count increments.
  - The 2 bytes left in the pipe at eop are the CRC16 and are discarded.
  - Count 64 with a full pipe plus another byte_done → ERR. A 67th byte after the PID means overflow.
  - eop with fewer than 2 bytes in the pipe, or with crc16_err=1 → ERROR.
- HSHK: any byte_done → ERR. eop → ACK/NAK result.
- ERR: ignores everything until eop, then reports ERROR.
- byte_done and eop in the same cycle, in any non-IDLE state → ERROR. That byte is not stored.
- sync_byte outside IDLE is ignored.
- Every eop outside IDLE returns the FSM to IDLE.
- Payload bytes already stored before an error are not retracted. rx_byte_count reports them.

## Timing
- Reset values:
  - FSM state = IDLE, pipe empty.
  - All outputs 0: rx_packet=0, rx_byte_count=0, rx_data=0x00.
- rst mid-packet: the FSM returns to IDLE next cycle. No rx_done or store_rx_data is generated.
- store_rx_data is registered. It asserts the cycle after the triggering byte_done.
- rx_done, rx_packet and rx_byte_count are registered in the cycle after eop.
  - rx_packet and rx_byte_count hold until the next rx_done.
  - The FSM is in IDLE in that cycle and can accept sync_byte.
- CRC error inputs are sampled only in the eop cycle.
- The count register is 7-bit. It saturates at 64 and never wraps.

## Configuration
- USB_RX_SEQ_CRC_EN defined:
  - crc5_err and crc16_err are checked as described above.
  - crc5_clear and crc16_clear are driven.
- USB_RX_SEQ_CRC_EN not defined:
  - Both CRC error inputs are ignored.
  - crc5_clear and crc16_clear are tied 0.
  - All framing, PID and length checks remain.

## Test plan
- sync, byte 0xD2, eop → one cycle after eop: rx_done=1, rx_packet=5, rx_byte_count=0, no store_rx_data.
- sync, bytes 0x69 0x81 0x58, eop with crc5_err=0 → rx_packet=2. Repeat with crc5_err=1 → rx_packet=7 (macro defined) or 2 (undefined).
- sync, bytes 0xC3 0x11 0x22 0x33 0xAA 0xBB, eop → store pulses carrying 0x11, 0x22, 0x33 only, each one cycle after the byte_done of 0x33, 0xAA and 0xBB respectively; rx_packet=3; rx_byte_count=3.
- sync, byte 0xFF, then 2 bytes, eop → no stores, crc clears never pulse, rx_packet=7.
- DATA1 with 66 bytes after the PID → 64 stores, rx_packet=4. With 67 bytes → 64 stores, rx_packet=7, rx_byte_count=64.
- rst asserted after the third DATA byte → no rx_done. A following ACK packet → rx_packet=5.
